seq_divider_8: RTL and testbench

Iterative unsigned restoring divider: the inverse arithmetic path to the 8-bit add/subtract datapath. It reuses one subtract-with-borrow per cycle to compute quotient and remainder. It sits beside the adder/subtractor as a multi-cycle arithmetic unit, with valid/ready handshakes on both the operand side and the result side.

---
 rtl/seq_divider_8.sv | 105 ++++++++++
 tb/tb_seq_divider_8.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8.sv
// rtl/seq_divider_8.sv - iterative unsigned restoring divider with valid/ready handshakes
module seq_divider_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d   = divisor;
          cnt_d   = '0;
          state_d = CALC;
          if (divisor == '0) begin
            quo_d = '1;
            rem_d = dividend;
            dbz_d = 1'b1;
          end else begin
            quo_d = dividend;
            rem_d = '0;
            dbz_d = 1'b0;
          end
        end
      end
      CALC: begin
        // A zero-divisor result is already loaded; spend one cycle here so it surfaces one clock after accept.
        if (dbz_q) begin
          state_d = DONE;
        end else begin
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = rst_n && (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8.sv
// tb/tb_seq_divider_8.sv - self-checking bench for seq_divider_8
module tb_seq_divider_8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       busy;

  int errors;
  int checks;

  seq_divider_8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } vec_t;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic d);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; d = 1'b1;
    end else begin
      q = a / b; r = a % b; d = 1'b0;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the result handshake.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic ed, input int hold, input string nm);
    int lat;
    bit calc_bad;
    bit hold_bad;
    int exp_lat;
    exp_lat = (b == 8'd0) ? 1 : 8;
    out_ready = (hold == 0);
    chk(in_ready == 1'b1, {nm, " in_ready_idle"}, int'(in_ready), 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    calc_bad = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready || !busy) calc_bad = 1'b1;
      @(posedge clk);
      lat++;
    end
    chk(lat == exp_lat, {nm, " latency"}, lat, exp_lat);
    chk(!calc_bad, {nm, " in_ready_low_calc"}, int'(calc_bad), 0);
    chk(quotient == eq, {nm, " quotient"}, int'(quotient), int'(eq));
    chk(remainder == er, {nm, " remainder"}, int'(remainder), int'(er));
    chk(div_by_zero == ed, {nm, " div_by_zero"}, int'(div_by_zero), int'(ed));
    if (hold > 0) begin
      hold_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom);
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (!out_valid || in_ready || !busy || quotient != eq || remainder != er || div_by_zero != ed)
          hold_bad = 1'b1;
      end
      chk(!hold_bad, {nm, " held_under_backpressure"}, int'(hold_bad), 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold > 0) begin
      chk(!out_valid && in_ready, {nm, " idle_after_handshake"}, int'({out_valid, in_ready}), 1);
      chk(quotient == eq && remainder == er, {nm, " result_kept"}, int'(quotient), int'(eq));
    end else if (!out_valid && in_ready) begin
      checks++;
    end else begin
      chk(1'b0, {nm, " idle_after_handshake"}, int'({out_valid, in_ready}), 1);
    end
  endtask

  vec_t vecs[$];
  logic [7:0] rq, rr;
  logic       rd;
  logic [7:0] ra, rb;

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;

    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0});
    vecs.push_back('{8'd0,   8'd3,   8'd0,   8'd0,   1'b0});
    vecs.push_back('{8'd200, 8'd0,   8'd255, 8'd200, 1'b1});
    vecs.push_back('{8'd50,  8'd5,   8'd10,  8'd0,   1'b0});
    vecs.push_back('{8'd1,   8'd128, 8'd0,   8'd1,   1'b0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(in_ready == 1'b0, "reset in_ready", int'(in_ready), 0);
    chk(out_valid == 1'b0 && busy == 1'b0, "reset out_valid_busy", int'({out_valid, busy}), 0);
    chk(quotient == 8'd0 && remainder == 8'd0 && div_by_zero == 1'b0, "reset outputs",
        int'({div_by_zero, quotient, remainder}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(in_ready == 1'b1, "post_reset in_ready", int'(in_ready), 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, 0, $sformatf("vec%0d", i));
    end

    run_op(8'd81, 8'd9, 8'd9, 8'd0, 1'b0, 5, "backpressure");

    // abort mid-calculation
    dividend = 8'd123; divisor = 8'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(in_ready == 1'b0 && out_valid == 1'b0 && busy == 1'b0, "abort handshake_outputs",
        int'({in_ready, out_valid, busy}), 0);
    chk(quotient == 8'd0 && remainder == 8'd0 && div_by_zero == 1'b0, "abort result_outputs",
        int'({div_by_zero, quotient, remainder}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd123, 8'd4, 8'd30, 8'd3, 1'b0, 0, "after_abort");

    for (int n = 0; n < 2000; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      ref_div(ra, rb, rq, rr, rd);
      run_op(ra, rb, rq, rr, rd, (n % 100 == 99) ? 2 : 0, $sformatf("rand%0d_%0d/%0d", n, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
